// File: rtl/usb_app_pkg.sv
// Shared definitions for the usb_app block-RAM stream readers:
// reader FSM states and the smallest output FIFO that sustains one word per cycle.
package usb_app_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Two entries cover the issued-but-not-captured read; the third keeps the sink fed.
  localparam int MIN_FIFO_DEPTH = 3;

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Read data is forced to zero while empty so idle stream outputs are clean.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + 1'b1;
  endfunction

  assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
  assign do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign pop_data  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      if (do_push_s && !do_pop_s)      count_r <= count_r + 1'b1;
      else if (!do_push_s && do_pop_s) count_r <= count_r - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads cmd_len consecutive words from a registered-address RAM starting at cmd_addr
// and streams them out on valid/ready with a last flag and a completion pulse.
module ram_stream_reader
  import usb_app_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LEN_W = ADDR_WIDTH + 1;

  if (FIFO_DEPTH < MIN_FIFO_DEPTH) begin : g_bad_depth
    $error("ram_stream_reader: FIFO_DEPTH below MIN_FIFO_DEPTH");
  end

  state_t                state_r;
  state_t                state_next_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] ram_raddr_r;
  logic [LEN_W-1:0]      remaining_r;
  logic                  pending_r;
  logic                  pending_last_r;
  logic                  accept_s;
  logic                  issue_s;
  logic                  final_issue_s;
  logic                  pop_s;
  logic                  drained_s;
  logic                  fifo_empty_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic [CNT_W:0]        occupancy_s;
  logic [DATA_WIDTH:0]   fifo_rdata_s;

  assign accept_s      = cmd_valid && (state_r == ST_IDLE);
  // A pending read will land next cycle, so it already claims a FIFO slot.
  assign occupancy_s   = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, pending_r};
  assign issue_s       = (state_r == ST_READ) && (occupancy_s < (CNT_W + 1)'(FIFO_DEPTH));
  assign final_issue_s = issue_s && (remaining_r == LEN_W'(1'b1));
  assign pop_s         = out_valid && out_ready;
  assign drained_s     = !pending_r &&
                         (fifo_empty_s || ((fifo_count_s == CNT_W'(1'b1)) && pop_s));

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd_len == {LEN_W{1'b0}}) state_next_s = ST_DONE;
          else                          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (final_issue_s) state_next_s = ST_DRAIN;
        else               state_next_s = ST_READ;
      end
      ST_DRAIN: begin
        if (drained_s) state_next_s = ST_DONE;
        else           state_next_s = ST_DRAIN;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, address/remaining counters, RAM address register and read-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      addr_r         <= {ADDR_WIDTH{1'b0}};
      remaining_r    <= {LEN_W{1'b0}};
      ram_raddr_r    <= {ADDR_WIDTH{1'b0}};
      pending_r      <= 1'b0;
      pending_last_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        addr_r      <= cmd_addr;
        remaining_r <= cmd_len;
      end else if (issue_s) begin
        addr_r      <= addr_r + 1'b1;
        remaining_r <= remaining_r - 1'b1;
      end
      if (issue_s) ram_raddr_r <= addr_r;
      pending_r      <= issue_s;
      pending_last_r <= final_issue_s;
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pending_r),
    .push_data ({pending_last_r, ram_dout}),
    .pop       (pop_s),
    .pop_data  (fifo_rdata_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);
  assign ram_raddr = ram_raddr_r;
  assign out_valid = !fifo_empty_s;
  assign out_data  = fifo_rdata_s[DATA_WIDTH-1:0];
  assign out_last  = fifo_rdata_s[DATA_WIDTH];

endmodule
